regfile_write_arbiter: RTL

- Shares the single synchronous write port of the 32x32 MIPS register file between two writeback requesters: A (ALU result) and B (load/memory result).
- Arbitrates round-robin with a valid/ready handshake and registers the winning request onto RegWrite/WriteRegister/WriteData.
- Drops writes to $zero so no write pulse is ever generated for register 0.
- Flags pending-write hazards for both regfile read addresses and keeps a saturating count of committed writes.

---
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 72 +++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between two write requesters, the arbiter and the regfile write/read ports.
// The requester side (master) drives requests and read addresses; the arbiter (slave) drives grants and the write port.
interface regfile_write_arbiter_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   Stall;
    logic                   ReqAValid;
    logic                   ReqAReady;
    logic [4:0]             ReqAReg;
    logic [31:0]            ReqAData;
    logic                   ReqBValid;
    logic                   ReqBReady;
    logic [4:0]             ReqBReg;
    logic [31:0]            ReqBData;
    logic                   RegWrite;
    logic [4:0]             WriteRegister;
    logic [31:0]            WriteData;
    logic                   LastGrant;
    logic [4:0]             ReadRegister1;
    logic [4:0]             ReadRegister2;
    logic                   Hazard1;
    logic                   Hazard2;
    logic [COUNT_WIDTH-1:0] WriteCount;

    modport master (
        output Stall, ReqAValid, ReqAReg, ReqAData, ReqBValid, ReqBReg, ReqBData,
               ReadRegister1, ReadRegister2,
        input  ReqAReady, ReqBReady, RegWrite, WriteRegister, WriteData, LastGrant,
               Hazard1, Hazard2, WriteCount
    );

    modport slave (
        input  Stall, ReqAValid, ReqAReg, ReqAData, ReqBValid, ReqBReg, ReqBData,
               ReadRegister1, ReadRegister2,
        output ReqAReady, ReqBReady, RegWrite, WriteRegister, WriteData, LastGrant,
               Hazard1, Hazard2, WriteCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (A) and load (B) writeback; 1-cycle latency.
// Backpressure: Ready is granted combinationally, never while Stall or reset is asserted; $zero writes are accepted and dropped.
module regfile_write_arbiter #(
    parameter int COUNT_WIDTH    = 16,
    parameter bit RESET_PRIORITY = 1'b0
) (
    input logic                  Clk,
    input logic                  ResetN,
    regfile_write_arbiter_if.slave bus
);
    logic                   grant_a;
    logic                   grant_b;
    logic                   last_grant;
    logic                   reg_write;
    logic [4:0]             write_reg;
    logic [31:0]            write_data;
    logic [COUNT_WIDTH-1:0] write_count;
    logic [4:0]             win_reg;
    logic [31:0]            win_data;
    logic                   win_nonzero;

    // On a conflict, last_grant names the side that must wait.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (ResetN && !bus.Stall) begin
            if (bus.ReqAValid && bus.ReqBValid) begin
                grant_a = last_grant;
                grant_b = !last_grant;
            end else begin
                grant_a = bus.ReqAValid;
                grant_b = bus.ReqBValid;
            end
        end
    end

    assign win_reg     = grant_b ? bus.ReqBReg  : bus.ReqAReg;
    assign win_data    = grant_b ? bus.ReqBData : bus.ReqAData;
    assign win_nonzero = (win_reg != 5'd0);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            reg_write   <= 1'b0;
            write_reg   <= 5'd0;
            write_data  <= 32'd0;
            write_count <= '0;
            last_grant  <= ~RESET_PRIORITY;
        end else if (grant_a || grant_b) begin
            last_grant <= grant_b;
            write_reg  <= win_reg;
            write_data <= win_data;
            reg_write  <= win_nonzero;
            if (win_nonzero && (write_count != '1)) begin
                write_count <= write_count + 1'b1;
            end
        end else begin
            reg_write <= 1'b0;
        end
    end

    assign bus.ReqAReady     = grant_a;
    assign bus.ReqBReady     = grant_b;
    assign bus.RegWrite      = reg_write;
    assign bus.WriteRegister = write_reg;
    assign bus.WriteData     = write_data;
    assign bus.LastGrant     = last_grant;
    assign bus.WriteCount    = write_count;

    // reg_write is never set for $zero, so the register-0 guard only matters for the read address.
    assign bus.Hazard1 = reg_write && (write_reg == bus.ReadRegister1) && (bus.ReadRegister1 != 5'd0);
    assign bus.Hazard2 = reg_write && (write_reg == bus.ReadRegister2) && (bus.ReadRegister2 != 5'd0);
endmodule
